// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch sequencer.
//   ADDR_W_DEF / INSTR_W_DEF : default address / instruction widths
//   state_t                  : sequencer FSM state encoding
//   pc_t                     : program counter type at the default width
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef logic [ADDR_W_DEF-1:0] pc_t;

endpackage

// File: rtl/fetch_pc_counter.sv
// fetch_pc_counter: program counter register.
//   clock, reset  : clock and synchronous active-high reset (pc <- RESET_PC)
//   load/load_val : load a new pc (has priority over inc)
//   inc           : advance pc by one, wrapping modulo 2**ADDR_W
//   pc            : current pc
//   last          : pc is at the top address, so the next increment overflows
module fetch_pc_counter
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              last
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load)     pc_d = load_val;
    else if (inc) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= PC_RST;
    else       pc_q <= pc_d;
  end

  assign pc   = pc_q;
  assign last = &pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and fetch controller for a 256x8 instruction memory.
// Drives endereco (= pc), captures instrucao at posedge (memory reads on the
// preceding negedge) and hands instr_out/pc_out to the decoder over
// instr_valid/instr_ready. Supports start, jump redirect, halt and backpressure.
//   clock, reset            : clock, synchronous active-high reset
//   start, start_addr       : begin fetching (IDLE/HALTED only)
//   jump_valid, jump_target : redirect (RUN only)
//   halt_req                : stop after the current output is delivered
//   endereco, instrucao     : memory address / read data
//   instr_out, pc_out, instr_valid, instr_ready : decoder handshake
//   halted, wrap_err        : status
// Build option: FETCH_WRAP_TRAP_EN -- when defined, a load at the top address
// sets sticky wrap_err and stops instead of wrapping pc to 0.
//
// state     | meaning
// ST_IDLE   | after reset, waiting for start
// ST_RUN    | fetching, one instruction per cycle when the decoder is ready
// ST_DRAIN  | stopping; holding last output until the decoder takes it
// ST_HALTED | stopped, waiting for start
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  endereco,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted,
  output logic               wrap_err
);

`ifdef FETCH_WRAP_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t             state_d, state_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0]  pc_out_d, pc_out_q;
  logic               valid_d, valid_q;
  logic               halted_d, halted_q;
`ifdef FETCH_WRAP_TRAP_EN
  logic               wrap_err_d, wrap_err_q;
`endif

  logic              pc_load, pc_inc, pc_last, wrap_hit;
  logic [ADDR_W-1:0] pc_load_val, pc;

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc),
    .last     (pc_last)
  );

  // Only meaningful with the trap build; otherwise pc wraps silently.
  assign wrap_hit = pc_last & TRAP_EN;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
`ifdef FETCH_WRAP_TRAP_EN
    wrap_err_d  = wrap_err_q;
`endif
    pc_load     = 1'b0;
    pc_load_val = start_addr;
    pc_inc      = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_load     = 1'b1;
          pc_load_val = start_addr;
          valid_d     = 1'b0;
          halted_d    = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
          wrap_err_d  = 1'b0;
`endif
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          if (valid_q && !instr_ready) begin
            state_d = ST_DRAIN;
          end else begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
        end else if (jump_valid) begin
          // Flush: the held instruction is dropped even if accepted this edge.
          pc_load     = 1'b1;
          pc_load_val = jump_target;
          valid_d     = 1'b0;
        end else if (!valid_q || instr_ready) begin
          instr_d  = instrucao;
          pc_out_d = pc;
          valid_d  = 1'b1;
          if (wrap_hit) begin
`ifdef FETCH_WRAP_TRAP_EN
            wrap_err_d = 1'b1;
`endif
            state_d    = ST_DRAIN;
          end else begin
            pc_inc = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (instr_ready) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
      wrap_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
`ifdef FETCH_WRAP_TRAP_EN
      wrap_err_q <= wrap_err_d;
`endif
    end
  end

  assign endereco    = pc;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
`ifdef FETCH_WRAP_TRAP_EN
  assign wrap_err    = wrap_err_q;
`else
  assign wrap_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with a behavioural
// 256x8 memory that reads endereco on the falling edge.
module tb_fetch_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_addr;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       halt_req;
  logic [7:0] endereco;
  logic [7:0] instrucao;
  logic [7:0] instr_out;
  logic [7:0] pc_out;
  logic       instr_valid;
  logic       instr_ready;
  logic       halted;
  logic       wrap_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [256];

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .halt_req    (halt_req),
    .endereco    (endereco),
    .instrucao   (instrucao),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .wrap_err    (wrap_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) instrucao = mem[endereco];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_pc,
                           input logic [7:0] exp_instr);
    check({tag, " valid"}, {15'd0, instr_valid}, 16'd1);
    check({tag, " pc_out"}, {8'd0, pc_out}, {8'd0, exp_pc});
    check({tag, " instr_out"}, {8'd0, instr_out}, {8'd0, exp_instr});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[10] = 8'h05; mem[11] = 8'h02; mem[12] = 8'h01; mem[13] = 8'h1E;
    mem[20] = 8'hDE; mem[21] = 8'h33; mem[30] = 8'h77;

    reset = 1'b1; start = 1'b0; start_addr = '0; jump_valid = 1'b0;
    jump_target = '0; halt_req = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst valid", {15'd0, instr_valid}, 16'd0);
    check("rst pc_out", {8'd0, pc_out}, 16'd0);
    check("rst endereco", {8'd0, endereco}, 16'd0);
    check("rst halted", {15'd0, halted}, 16'd0);
    check("rst wrap_err", {15'd0, wrap_err}, 16'd0);

    // start at 10, decoder always ready
    start = 1'b1; start_addr = 8'd10; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    check("start valid", {15'd0, instr_valid}, 16'd0);
    check("start endereco", {8'd0, endereco}, 16'd10);
    tick(); check_out("seq0", 8'd10, 8'h05);
    tick(); check_out("seq1", 8'd11, 8'h02);

    // backpressure for 3 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("bp hold", 8'd11, 8'h02);
      check("bp endereco", {8'd0, endereco}, 16'd12);
    end
    instr_ready = 1'b1;
    tick(); check_out("bp release", 8'd12, 8'h01);

    // jump to 20
    jump_valid = 1'b1; jump_target = 8'd20;
    tick();
    jump_valid = 1'b0;
    check("jump flush", {15'd0, instr_valid}, 16'd0);
    check("jump endereco", {8'd0, endereco}, 16'd20);
    tick(); check_out("jump first", 8'd20, 8'hDE);

    // halt with pending output -> DRAIN
    instr_ready = 1'b0; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_out("drain hold", 8'd20, 8'hDE);
    check("drain halted", {15'd0, halted}, 16'd0);
    tick();
    check_out("drain hold2", 8'd20, 8'hDE);
    instr_ready = 1'b1;
    tick();
    check("drain done valid", {15'd0, instr_valid}, 16'd0);
    check("drain done halted", {15'd0, halted}, 16'd1);

    // restart at 13
    start = 1'b1; start_addr = 8'd13;
    tick();
    start = 1'b0;
    check("restart halted", {15'd0, halted}, 16'd0);
    check("restart valid", {15'd0, instr_valid}, 16'd0);
    tick(); check_out("restart first", 8'd13, 8'h1E);

    // halt with nothing pending (ready high) -> straight to HALTED
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt direct valid", {15'd0, instr_valid}, 16'd0);
    check("halt direct halted", {15'd0, halted}, 16'd1);

    // top-of-memory behaviour
    start = 1'b1; start_addr = 8'd254;
    tick();
    start = 1'b0;
    tick(); check_out("top 254", 8'd254, mem[254]);
    tick(); check_out("top 255", 8'd255, mem[255]);
`ifdef FETCH_WRAP_TRAP_EN
    check("trap wrap_err", {15'd0, wrap_err}, 16'd1);
    check("trap not yet halted", {15'd0, halted}, 16'd0);
    tick();
    check("trap valid", {15'd0, instr_valid}, 16'd0);
    check("trap halted", {15'd0, halted}, 16'd1);
    check("trap wrap_err sticky", {15'd0, wrap_err}, 16'd1);
    check("trap pc_out", {8'd0, pc_out}, 16'd255);
    tick();
    check("trap wrap_err sticky2", {15'd0, wrap_err}, 16'd1);
`else
    tick(); check_out("wrap 0", 8'd0, mem[0]);
    tick(); check_out("wrap 1", 8'd1, mem[1]);
    check("wrap no err", {15'd0, wrap_err}, 16'd0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("wrap halt", {15'd0, halted}, 16'd1);
`endif

    // reset mid-RUN with a valid output
    start = 1'b1; start_addr = 8'd30;
    tick();
    start = 1'b0;
    check("pre-reset wrap_err clr", {15'd0, wrap_err}, 16'd0);
    tick(); check_out("pre-reset", 8'd30, 8'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid rst valid", {15'd0, instr_valid}, 16'd0);
    check("mid rst pc_out", {8'd0, pc_out}, 16'd0);
    check("mid rst instr_out", {8'd0, instr_out}, 16'd0);
    check("mid rst endereco", {8'd0, endereco}, 16'd0);
    check("mid rst halted", {15'd0, halted}, 16'd0);
    jump_valid = 1'b1; jump_target = 8'd40;
    tick(); tick();
    jump_valid = 1'b0;
    check("idle jump endereco", {8'd0, endereco}, 16'd0);
    check("idle jump valid", {15'd0, instr_valid}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
